// File: rtl/sweep_eval_ctrl_if.sv
// rtl/sweep_eval_ctrl_if.sv - handshake, partition and result bus of the sweep evaluator
interface sweep_eval_ctrl_if #(
  parameter int NUM_IN  = 7,
  parameter int NUM_OUT = 4
);
  localparam int HAM_W = NUM_IN + $clog2(NUM_OUT + 1);
  localparam int ABS_W = NUM_IN + NUM_OUT;

  logic               start;
  logic               abort;
  logic [NUM_OUT-1:0] po_apx;
  logic [NUM_OUT-1:0] po_ref;
  logic [NUM_IN-1:0]  pi;
  logic               busy;
  logic               done;
  logic [NUM_IN:0]    mismatch_cnt;
  logic [HAM_W-1:0]   ham_sum;
  logic [ABS_W-1:0]   abs_sum;
  logic [NUM_OUT-1:0] max_abs;

  modport master (
    input  start, abort, po_apx, po_ref,
    output pi, busy, done, mismatch_cnt, ham_sum, abs_sum, max_abs
  );

  modport slave (
    output start, abort, po_apx, po_ref,
    input  pi, busy, done, mismatch_cnt, ham_sum, abs_sum, max_abs
  );
endinterface

// File: rtl/sweep_eval_ctrl.sv
// rtl/sweep_eval_ctrl.sv - exhaustive input sweep of an approximate partition with error accumulation
module sweep_eval_ctrl #(
  parameter int NUM_IN  = 7,
  parameter int NUM_OUT = 4,
  parameter int SETTLE  = 1
) (
  input logic             clk,
  input logic             rst,
  sweep_eval_ctrl_if.master bus
);
  localparam int PC_W  = $clog2(NUM_OUT + 1);
  localparam int HAM_W = NUM_IN + PC_W;
  localparam int ABS_W = NUM_IN + NUM_OUT;
  localparam int MIS_W = NUM_IN + 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_IN-1:0]  pi_q, pi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MIS_W-1:0]   mis_q, mis_d;
  logic [HAM_W-1:0]   ham_q, ham_d;
  logic [ABS_W-1:0]   abs_q, abs_d;
  logic [NUM_OUT-1:0] max_q, max_d;

  logic               busy, done;
  logic [NUM_OUT-1:0] xor_v;
  logic [PC_W-1:0]    popcnt;
  logic [NUM_OUT:0]   diff_pos, diff_neg;
  logic [NUM_OUT-1:0] absd;
  logic               sample;

  // Difference is formed one bit wider so the sign of apx - ref is visible.
  always_comb begin
    xor_v    = bus.po_apx ^ bus.po_ref;
    popcnt   = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      popcnt = popcnt + PC_W'(xor_v[i]);
    end
    diff_pos = {1'b0, bus.po_apx} - {1'b0, bus.po_ref};
    diff_neg = {1'b0, bus.po_ref} - {1'b0, bus.po_apx};
    absd     = diff_pos[NUM_OUT] ? diff_neg[NUM_OUT-1:0] : diff_pos[NUM_OUT-1:0];
    sample   = (cnt_q == CNT_W'(SETTLE - 1));
  end

  always_comb begin
    state_d = state_q;
    pi_d    = pi_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    ham_d   = ham_q;
    abs_d   = abs_q;
    max_d   = max_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          pi_d    = '0;
          cnt_d   = '0;
          mis_d   = '0;
          ham_d   = '0;
          abs_d   = '0;
          max_d   = '0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Abort wins over a coinciding sample edge; partial results are kept.
        if (bus.abort) begin
          state_d = S_IDLE;
          pi_d    = '0;
          cnt_d   = '0;
        end else if (sample) begin
          cnt_d = '0;
          mis_d = mis_q + MIS_W'(|xor_v);
          ham_d = ham_q + HAM_W'(popcnt);
          abs_d = abs_q + ABS_W'(absd);
          if (absd > max_q) max_d = absd;
          if (pi_q == '1) begin
            pi_d    = '0;
            state_d = S_DONE;
          end else begin
            pi_d = pi_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pi_q    <= '0;
      cnt_q   <= '0;
      mis_q   <= '0;
      ham_q   <= '0;
      abs_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      pi_q    <= pi_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      ham_q   <= ham_d;
      abs_q   <= abs_d;
      max_q   <= max_d;
    end
  end

  assign bus.pi           = pi_q;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.mismatch_cnt = mis_q;
  assign bus.ham_sum      = ham_q;
  assign bus.abs_sum      = abs_q;
  assign bus.max_abs      = max_q;
endmodule

// File: tb/tb_sweep_eval_ctrl.sv
// tb/tb_sweep_eval_ctrl.sv - directed checks of sweep_eval_ctrl with SETTLE=1 and SETTLE=3 instances
module tb_sweep_eval_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;
  int   total = 0;
  int   passed = 0;
  int   cyc, bcyc, d1;
  logic seen_done;

  always #5 clk = ~clk;

  sweep_eval_ctrl_if #(.NUM_IN(7), .NUM_OUT(4)) bus1 ();
  sweep_eval_ctrl_if #(.NUM_IN(7), .NUM_OUT(4)) bus3 ();

  sweep_eval_ctrl #(.NUM_IN(7), .NUM_OUT(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
  sweep_eval_ctrl #(.NUM_IN(7), .NUM_OUT(4), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

  // Partition model: 0 = exact copy, 1 = constant zero, 2 = bitwise inverse of pi[3:0]
  always_comb begin
    bus1.po_ref = bus1.pi[3:0];
    bus3.po_ref = bus3.pi[3:0];
    case (mode)
      1:       begin bus1.po_apx = 4'd0;           bus3.po_apx = 4'd0;           end
      2:       begin bus1.po_apx = ~bus1.pi[3:0];  bus3.po_apx = ~bus3.pi[3:0];  end
      default: begin bus1.po_apx = bus1.pi[3:0];   bus3.po_apx = bus3.pi[3:0];   end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_res1(input string tag, input int m, input int h, input int a, input int x);
    chk({tag, "_mis"}, 32'(bus1.mismatch_cnt), m);
    chk({tag, "_ham"}, 32'(bus1.ham_sum), h);
    chk({tag, "_abs"}, 32'(bus1.abs_sum), a);
    chk({tag, "_max"}, 32'(bus1.max_abs), x);
  endtask

  task automatic start1;
    bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
  endtask

  initial begin
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus3.start = 1'b0; bus3.abort = 1'b0;
    #1;
    chk("rst_pi", 32'(bus1.pi), 0);
    chk("rst_busy", 32'(bus1.busy), 0);
    chk("rst_done", 32'(bus1.done), 0);
    chk_res1("rst", 0, 0, 0, 0);
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // Equal partitions: 128 busy cycles, done after edge E0+128, zero error
    mode = 0;
    start1();
    chk("t1_busy_e0", 32'(bus1.busy), 1);
    chk("t1_pi_e0", 32'(bus1.pi), 0);
    cyc = 0; bcyc = 0;
    while (!bus1.done && cyc < 1000) begin
      if (bus1.busy) bcyc++;
      @(posedge clk); #1; cyc++;
    end
    chk("t1_done_cyc", cyc, 128);
    chk("t1_busy_cycles", bcyc, 128);
    chk("t1_busy_in_done", 32'(bus1.busy), 0);
    chk_res1("t1", 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(bus1.done), 0);

    // Zero approximation, both SETTLE values started on the same edge
    mode = 1;
    bus1.start = 1'b1; bus3.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0; bus3.start = 1'b0;
    cyc = 0; d1 = -1;
    while (!bus3.done && cyc < 2000) begin
      if (bus1.done) d1 = cyc;
      @(posedge clk); #1; cyc++;
    end
    chk("t2_done1_cyc", d1, 128);
    chk("t2_done3_cyc", cyc, 384);
    chk_res1("t2_s1", 120, 256, 960, 15);
    chk("t2_s3_mis", 32'(bus3.mismatch_cnt), 120);
    chk("t2_s3_ham", 32'(bus3.ham_sum), 256);
    chk("t2_s3_abs", 32'(bus3.abs_sum), 960);
    chk("t2_s3_max", 32'(bus3.max_abs), 15);
    @(posedge clk); #1;

    // Inverted approximation
    mode = 2;
    start1();
    cyc = 0;
    while (!bus1.done && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("t3_done_cyc", cyc, 128);
    chk_res1("t3", 128, 512, 1024, 15);
    @(posedge clk); #1;

    // Abort on the sample edge of vector 9: only vectors 0..8 accumulate
    mode = 1;
    start1();
    repeat (9) @(posedge clk);
    #1;
    chk("t4_pi_before", 32'(bus1.pi), 9);
    bus1.abort = 1'b1;
    @(posedge clk);
    #1 bus1.abort = 1'b0;
    chk("t4_busy", 32'(bus1.busy), 0);
    chk("t4_pi", 32'(bus1.pi), 0);
    chk_res1("t4", 8, 13, 36, 8);
    seen_done = 1'b0;
    for (int i = 0; i < 140; i++) begin
      if (bus1.done || bus1.busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("t4_no_done_or_busy", 32'(seen_done), 0);

    // Asynchronous reset mid-run clears everything without a clock edge
    start1();
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_pi", 32'(bus1.pi), 0);
    chk("t5_rst_busy", 32'(bus1.busy), 0);
    chk_res1("t5_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_idle_after_rst", 32'(bus1.busy), 0);

    // start during RUN neither restarts nor clears
    start1();
    repeat (10) @(posedge clk);
    #1 bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    chk("t5_run_pi", 32'(bus1.pi), 11);
    chk("t5_run_mis", 32'(bus1.mismatch_cnt), 10);
    cyc = 11;
    while (!bus1.done && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("t5_done_cyc", cyc, 128);
    chk_res1("t5_full", 120, 256, 960, 15);

    // start during the DONE cycle is dropped
    bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    chk("t5_dstart_busy", 32'(bus1.busy), 0);
    chk("t5_dstart_done", 32'(bus1.done), 0);
    @(posedge clk); #1;
    chk("t5_dstart_idle", 32'(bus1.busy), 0);
    chk_res1("t5_hold", 120, 256, 960, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sweep_eval_ctrl.md
Name: sweep_eval_ctrl

Overview:
- Controller that exhaustively sequences a NUM_IN-input / NUM_OUT-output combinational partition through all 2^NUM_IN input vectors.
- Drives one shared pi bus into both the approximate partition and its exact counterpart.
- Samples both po buses after a programmable settle window and accumulates error metrics: mismatch count, Hamming-error sum, absolute-error sum and maximum absolute error.
- Sits between the partition under evaluation and the host/scan logic that reads the results after a start/done handshake.

Parameters:
- NUM_IN, 7: number of partition inputs; the sweep length is 2^NUM_IN vectors.
- NUM_OUT, 4: number of partition outputs; po is interpreted as unsigned.
- SETTLE, 1: cycles each vector is held before its outputs are sampled; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE
- abort  in  1  terminate a running sweep
- po_apx  in  NUM_OUT  outputs of the approximate partition
- po_ref  in  NUM_OUT  outputs of the exact partition
- pi  out  NUM_IN  vector driven to both partitions
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when a sweep completes normally
- mismatch_cnt  out  NUM_IN+1  number of vectors where po_apx != po_ref
- ham_sum  out  NUM_IN+clog2(NUM_OUT+1)  sum over vectors of popcount(po_apx ^ po_ref)
- abs_sum  out  NUM_IN+NUM_OUT  sum over vectors of |po_apx - po_ref|
- max_abs  out  NUM_OUT  maximum |po_apx - po_ref| over sampled vectors

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - pi, busy, done and all accumulators go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 -> RUN.
  - At E0: pi=0, all accumulators cleared, settle counter=0, busy=1.
  - abort in IDLE has no effect.
- RUN:
  - The settle counter counts 0..SETTLE-1 per vector.
  - Outputs are sampled at the edge where the counter equals SETTLE-1, i.e. at E0+SETTLE*k for k=1..2^NUM_IN.
  - At each sample edge all four accumulators update from the current po_apx/po_ref, and pi increments (vector k-1 is being sampled).
  - The absolute difference is computed on NUM_OUT-bit unsigned values, widened by 1 bit before subtraction.
  - max_abs updates only when the new difference is strictly greater than the stored value.
  - Accumulator widths are sized so no overflow is possible; no saturation logic is needed.
- Final sample edge (k=2^NUM_IN):
  - Accumulators update; pi returns to 0 (it does not wrap through the increment path).
  - busy=0, next state DONE.
- DONE:
  - Lasts exactly one cycle, with done=1; then -> IDLE.
  - start during the DONE cycle is ignored.
- Result hold: results hold their values until the next accepted start or reset.
- Sweep timing:
  - Total sweep length is 2^NUM_IN*SETTLE cycles from E0.
  - done is high in the cycle after edge E0+2^NUM_IN*SETTLE.
- abort in RUN:
  - Next edge -> IDLE; pi=0, busy=0, done stays 0.
  - Accumulators keep their partial values. No sample is taken at the abort edge, even if it coincides with a sample edge; abort has priority.
- start while in RUN or DONE is ignored; it neither restarts nor clears the sweep.
- Input timing: po_apx/po_ref are purely combinational from pi; no input registering is done.

Test Plan:
- po_apx and po_ref both tied to pi[3:0], SETTLE=1, pulse start -> busy for 128 cycles; done at cycle 129; all four accumulators = 0.
- po_apx=0, po_ref=pi[3:0], SETTLE=1 -> mismatch_cnt=120, ham_sum=256, abs_sum=960, max_abs=15.
- Same stimulus, SETTLE=3 -> done in the cycle after E0+384; results identical to the SETTLE=1 run.
- po_apx=~pi[3:0], po_ref=pi[3:0] -> mismatch_cnt=128, ham_sum=512, max_abs=15, abs_sum=1024.
- Abort asserted on the sample edge of vector 9 (SETTLE=1, po_apx=0, po_ref=pi[3:0]) -> IDLE next cycle; done never pulses; mismatch_cnt=8 (vectors 1..8); pi=0.
- Assert rst mid-RUN, then start during RUN, then start during the DONE cycle:
  - rst -> all outputs 0 immediately.
  - start during RUN -> no restart; accumulators continue.
  - start during the DONE cycle -> state returns to IDLE with no new sweep.
